// File: rtl/trg_delay_gen.sv
// Trigger-delay emitter: one-cycle STOP pulse DLY cycles after each START, with a due-time FIFO.
// Optional macro TRG_DELAY_STATS_EN builds the saturating DROP_CNT counter; otherwise DROP_CNT is 0.
module trg_delay_gen #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          HOLDOFF,
  input  logic          START,
  input  logic [DW-1:0] DLY,
  output logic          STOP,
  output logic [AW:0]   PEND,
  output logic          FULL,
  output logic          OVF,
  output logic [7:0]    DROP_CNT
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] ts;
  logic [DW-1:0] dly_r;
  logic [DW-1:0] dly_eff;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] due_mem [DEPTH];
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  assign PEND    = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign FULL    = (PEND == (AW+1)'(DEPTH));
  assign dly_eff = (DLY == '0) ? DW'(1) : DLY;

  // A pop frees a slot on the same edge, so a START against a full FIFO is still accepted then.
  assign pop  = !HOLDOFF && !empty && (due_mem[rd_ptr[AW-1:0]] == ts);
  assign push = START && !HOLDOFF && (!FULL || pop);
  assign drop = START && !HOLDOFF && FULL && !pop;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ts     <= '0;
      dly_r  <= DW'(1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      STOP   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      ts <= ts + DW'(1);
      // Reloading only when idle keeps the queued due times monotonic.
      if ((PEND == '0) && !START) dly_r <= dly_eff;
      if (HOLDOFF) begin
        rd_ptr <= wr_ptr;
        STOP   <= 1'b0;
      end else begin
        STOP <= pop;
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (drop) OVF <= 1'b1;
    end
  end

  // NOTE: the due-time storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (push) due_mem[wr_ptr[AW-1:0]] <= ts + dly_r;
  end

`ifdef TRG_DELAY_STATS_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                              drop_cnt <= 8'h00;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'h01;
  end

  assign DROP_CNT = drop_cnt;
`else
  assign DROP_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_trg_delay_gen.sv
// Self-checking bench for trg_delay_gen: absolute-time queue model, per-cycle compare, directed and random stimulus.
module tb_trg_delay_gen;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic          HOLDOFF = 1'b0;
  logic          START = 1'b0;
  logic [DW-1:0] DLY = '0;
  logic          STOP;
  logic [AW:0]   PEND;
  logic          FULL;
  logic          OVF;
  logic [7:0]    DROP_CNT;

  int total = 0;
  int bad   = 0;

  // Model state: due times are absolute edge numbers, so no modulo arithmetic is involved.
  int due_q[$];
  int m_dly     = 1;
  int edge_no   = 0;
  int since_rst = 0;
  bit m_stop    = 1'b0;
  bit m_ovf     = 1'b0;
  int m_drops   = 0;
  int pulses[$];

  trg_delay_gen #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .CLR(CLR), .HOLDOFF(HOLDOFF), .START(START), .DLY(DLY),
    .STOP(STOP), .PEND(PEND), .FULL(FULL), .OVF(OVF), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef TRG_DELAY_STATS_EN
    return (m_drops > 255) ? 255 : m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    due_q.delete();
    m_dly     = 1;
    since_rst = 0;
    m_stop    = 1'b0;
    m_ovf     = 1'b0;
    m_drops   = 0;
  endtask

  task automatic model_edge();
    int pend0;
    bit pop;
    pend0 = due_q.size();
    pop   = !HOLDOFF && (pend0 > 0) && (due_q[0] == edge_no);
    if (HOLDOFF) begin
      due_q.delete();
      m_stop = 1'b0;
    end else begin
      m_stop = pop;
      if (pop) void'(due_q.pop_front());
      if (START) begin
        if ((pend0 == DEPTH) && !pop) begin
          m_ovf = 1'b1;
          m_drops++;
        end else begin
          due_q.push_back(edge_no + m_dly);
        end
      end
    end
    if ((pend0 == 0) && !START) m_dly = (DLY == '0) ? 1 : int'(DLY);
    since_rst++;
    edge_no++;
  endtask

  task automatic step(input bit s, input int d, input bit h);
    START   = s;
    DLY     = DW'(d);
    HOLDOFF = h;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  // Idle steps numbered k_first.. ; records the k of every observed STOP pulse.
  task automatic watch(input int k_first, input int n, input int d);
    pulses.delete();
    for (int k = k_first; k < k_first + n; k++) begin
      step(1'b0, d, 1'b0);
      if (STOP === 1'b1) pulses.push_back(k);
    end
  endtask

  function automatic int first_pulse();
    return (pulses.size() > 0) ? pulses[0] : -1;
  endfunction

  always @(negedge CLK) begin
    if (!CLR) begin
      check("stop",     32'(STOP),     32'(m_stop));
      check("pend",     32'(PEND),     32'(due_q.size()));
      check("full",     32'(FULL),     32'(due_q.size() == DEPTH));
      check("ovf",      32'(OVF),      32'(m_ovf));
      check("drop_cnt", 32'(DROP_CNT), 32'(exp_drop()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_stop", 32'(STOP), 0);
    check("rst_pend", 32'(PEND), 0);
    check("rst_full", 32'(FULL), 0);
    check("rst_ovf",  32'(OVF),  0);
    check("rst_drop", 32'(DROP_CNT), 0);
    CLR = 1'b0;

    // Single trigger, DLY=5.
    step(1'b0, 5, 1'b0);
    step(1'b1, 5, 1'b0);
    check("t2_pend_after_start", 32'(PEND), 1);
    watch(1, 10, 5);
    check("t2_npulse", 32'(pulses.size()), 1);
    check("t2_at",     32'(first_pulse()), 5);
    check("t2_pend_end", 32'(PEND), 0);

    // Three back-to-back triggers, DLY=4.
    step(1'b0, 4, 1'b0);
    step(1'b1, 4, 1'b0);
    step(1'b1, 4, 1'b0);
    step(1'b1, 4, 1'b0);
    check("t3_pend_peak", 32'(PEND), 3);
    watch(3, 8, 4);
    check("t3_npulse", 32'(pulses.size()), 3);
    check("t3_p0", 32'(first_pulse()), 4);
    if (pulses.size() == 3) begin
      check("t3_p1", 32'(pulses[1]), 5);
      check("t3_p2", 32'(pulses[2]), 6);
    end

    // Overflow: 9 starts into an 8-deep FIFO, DLY=100.
    step(1'b0, 100, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 100, 1'b0);
      if (i == 7) check("t4_full", 32'(FULL), 1);
    end
    check("t4_ovf",  32'(OVF), 1);
    check("t4_pend", 32'(PEND), 8);
`ifdef TRG_DELAY_STATS_EN
    check("t4_drop", 32'(DROP_CNT), 1);
`else
    check("t4_drop", 32'(DROP_CNT), 0);
`endif
    watch(9, 105, 100);
    check("t4_npulse", 32'(pulses.size()), 8);
    check("t4_first",  32'(first_pulse()), 100);

    // Async CLR mid-run with 3 pending.
    step(1'b0, 30, 1'b0);
    repeat (3) step(1'b1, 30, 1'b0);
    #2 CLR = 1'b1;
    model_reset();
    #1;
    check("t1_stop", 32'(STOP), 0);
    check("t1_pend", 32'(PEND), 0);
    check("t1_ovf",  32'(OVF),  0);
    @(negedge CLK);
    CLR = 1'b0;
    watch(0, 40, 30);
    check("t1_npulse", 32'(pulses.size()), 0);

    // Wrap: START when ts=250 with DLY=10, then DLY=0.
    step(1'b0, 10, 1'b0);
    for (int i = 0; i < 300 && (since_rst % 256) != 250; i++) step(1'b0, 10, 1'b0);
    step(1'b1, 10, 1'b0);
    watch(1, 14, 10);
    check("t5_npulse", 32'(pulses.size()), 1);
    check("t5_at",     32'(first_pulse()), 10);
    step(1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    watch(1, 4, 0);
    check("t5_d0_npulse", 32'(pulses.size()), 1);
    check("t5_d0_at",     32'(first_pulse()), 1);

    // HOLDOFF flush with 2 pending.
    step(1'b0, 50, 1'b0);
    step(1'b1, 50, 1'b0);
    step(1'b1, 50, 1'b0);
    step(1'b0, 50, 1'b1);
    check("t6_pend_flush", 32'(PEND), 0);
    watch(3, 60, 50);
    check("t6_npulse", 32'(pulses.size()), 0);

    // DLY change while pending has no effect.
    step(1'b0, 20, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b0, 5, 1'b0);
    step(1'b1, 5, 1'b0);
    watch(3, 25, 5);
    check("t6_dly_npulse", 32'(pulses.size()), 2);
    check("t6_dly_p0", 32'(first_pulse()), 20);
    if (pulses.size() == 2) check("t6_dly_p1", 32'(pulses[1]), 22);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), ($urandom_range(0, 99) < 3));
    end
    repeat (50) step(1'b0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
